rx_control: RTL

- Receive-side counterpart of the bridge's transmit control path.
- Accepts a byte stream from the RX MAC (data/valid/last/error), stores one complete frame, and applies length and error checks.
- Forwards each accepted frame to the bridge core through a valid/ready byte interface, with the frame length and a last-byte marker.
- Single-frame store-and-forward. The MAC side has no backpressure, so bytes that cannot be stored are discarded and counted.

---
 rtl/rx_control.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/rx_control.sv
// -----------------------------------------------------------------------------
// rx_control
//   Receive-side control path of the bridge. Captures one complete frame from
//   the RX MAC byte stream into a local buffer, applies length/error checks,
//   then forwards the accepted frame to the bridge core over a valid/ready
//   byte interface. Single-frame store-and-forward: the MAC cannot be stalled,
//   so frames that cannot be stored are discarded and counted.
//
// Parameters
//   DEPTH    buffer size in bytes (power of two), largest storable frame
//   MIN_LEN  smallest accepted frame length, FCS included (assumed >= 5)
//   AW       buffer address width, log2(DEPTH)
//
// Ports
//   clk, rst                  clock (rising edge) / async active-low reset
//   rx_mac_data/valid/last/err  byte stream from the RX MAC; err is sampled
//                             with the last byte
//   rx_data_o/valid_o/last_o  frame bytes to the core, registered
//   rx_ready_i                core accepts the byte when rx_valid_o is high
//   frm_len_o                 length of the frame being delivered
//   rx_busy_o                 high while a frame is being delivered
//   drop_cnt_o                saturating count of discarded frames
//
// Build option
//   RX_FCS_STRIP_EN  when defined, the 4 FCS bytes are not delivered:
//                    frm_len_o = L-4 and delivery stops after L-4 bytes.
//                    The minimum-length check still uses the full length.
// -----------------------------------------------------------------------------
module rx_control #(
  parameter int DEPTH   = 256,
  parameter int MIN_LEN = 64,
  parameter int AW      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_mac_data,
  input  logic        rx_mac_valid,
  input  logic        rx_mac_last,
  input  logic        rx_mac_err,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  output logic        rx_last_o,
  input  logic        rx_ready_i,
  output logic [15:0] frm_len_o,
  output logic        rx_busy_o,
  output logic [15:0] drop_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_DROP, S_SEND} state_t;

  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [15:0] MIN_L    = 16'(MIN_LEN);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_in_frame;
  logic          w_in_frame_nxt;
  logic [AW:0]   r_cnt;         // bytes stored so far; reaches DEPTH when full
  logic [AW-1:0] r_rd_ptr;      // index of the byte presented on rx_data_o
  logic [7:0]    r_mem [DEPTH];
  logic [7:0]    r_data;
  logic          r_valid;
  logic [15:0]   r_frm_len;
  logic [15:0]   r_drop_cnt;

  // ---------------------------------------------------------------------------
  // Control strobes
  // ---------------------------------------------------------------------------
  logic          w_mac_last;
  logic          w_wr_en;
  logic [AW-1:0] w_wr_addr;
  logic          w_cnt_start;
  logic          w_drop_inc;
  logic          w_load_send;
  logic          w_pop;
  logic          w_at_last;
  logic [15:0]   w_len;
  logic [15:0]   w_deliv_len;
  logic [AW-1:0] w_rd_nxt;

  assign w_mac_last = rx_mac_valid & rx_mac_last;

  // Length the frame will have once the byte on the bus is stored.
  assign w_len = 16'(r_cnt) + 16'd1;

`ifdef RX_FCS_STRIP_EN
  assign w_deliv_len = w_len - 16'd4;
`else
  assign w_deliv_len = w_len;
`endif

  assign w_at_last = (16'(r_rd_ptr) == (r_frm_len - 16'd1));
  assign w_rd_nxt  = r_rd_ptr + AW'(1);

  // MAC framing is followed in every state so that a frame which started
  // while we could not take it is skipped as a whole.
  always_comb begin
    w_in_frame_nxt = r_in_frame;
    if (rx_mac_valid) w_in_frame_nxt = ~rx_mac_last;
  end

  // ---------------------------------------------------------------------------
  // Next-state / strobe logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    w_wr_addr   = r_cnt[AW-1:0];
    w_cnt_start = 1'b0;
    w_drop_inc  = 1'b0;
    w_load_send = 1'b0;
    w_pop       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (r_in_frame) begin
          // Tail of a frame whose head we missed: skip it. If its last byte
          // is on the bus right now, count it here rather than in DROP.
          if (w_mac_last) w_drop_inc  = 1'b1;
          else            w_state_nxt = S_DROP;
        end else if (rx_mac_valid) begin
          w_wr_en     = 1'b1;
          w_wr_addr   = '0;
          w_cnt_start = 1'b1;
          // A one-byte frame is always a runt.
          if (rx_mac_last) w_drop_inc  = 1'b1;
          else             w_state_nxt = S_RECV;
        end
      end

      S_RECV: begin
        if (rx_mac_valid) begin
          if (r_cnt == CNT_FULL) begin
            // Buffer full: a DEPTH+1 byte frame ending here is dropped at
            // once, a longer one is skipped until its last byte.
            if (rx_mac_last) begin
              w_drop_inc  = 1'b1;
              w_state_nxt = S_IDLE;
            end else begin
              w_state_nxt = S_DROP;
            end
          end else begin
            w_wr_en = 1'b1;
            if (rx_mac_last) begin
              if (rx_mac_err || (w_len < MIN_L)) begin
                w_drop_inc  = 1'b1;
                w_state_nxt = S_IDLE;
              end else begin
                w_load_send = 1'b1;
                w_state_nxt = S_SEND;
              end
            end
          end
        end
      end

      S_DROP: begin
        if (w_mac_last) begin
          w_drop_inc  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end

      S_SEND: begin
        // MAC bytes are discarded while the buffer is busy delivering.
        if (w_mac_last) w_drop_inc = 1'b1;
        if (r_valid && rx_ready_i) begin
          w_pop = 1'b1;
          // Use the post-cycle framing so a last byte arriving on the exit
          // cycle (already counted above) does not send us to DROP.
          if (w_at_last) w_state_nxt = w_in_frame_nxt ? S_DROP : S_IDLE;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_in_frame <= 1'b0;
      r_cnt      <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_frame <= w_in_frame_nxt;
      if (w_cnt_start)  r_cnt <= (AW+1)'(1);
      else if (w_wr_en) r_cnt <= r_cnt + (AW+1)'(1);
      if (w_drop_inc && (r_drop_cnt != 16'hFFFF))
        r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  // Frame buffer: contents are not reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_wr_addr] <= rx_mac_data;
  end

  // ---------------------------------------------------------------------------
  // Delivery datapath. Byte 0 is preloaded on the cycle the frame is
  // accepted so rx_valid_o rises on the very next cycle; each handshake
  // fetches the following byte, giving one byte per cycle back-to-back.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_rd_ptr  <= '0;
      r_frm_len <= '0;
    end else if (w_load_send) begin
      r_valid   <= 1'b1;
      r_data    <= r_mem[0];
      r_rd_ptr  <= '0;
      r_frm_len <= w_deliv_len;
    end else if (w_pop) begin
      if (w_at_last) begin
        r_valid <= 1'b0;
      end else begin
        r_rd_ptr <= w_rd_nxt;
        r_data   <= r_mem[w_rd_nxt];
      end
    end
  end

  assign rx_data_o  = r_data;
  assign rx_valid_o = r_valid;
  assign rx_last_o  = r_valid & w_at_last;
  assign frm_len_o  = r_frm_len;
  assign rx_busy_o  = (r_state == S_SEND);
  assign drop_cnt_o = r_drop_cnt;

endmodule
